// File: rtl/network_mul_share_arbiter.sv
// -----------------------------------------------------------------------------
// network_mul_share_arbiter
//
// Purpose:
//    Shares one external pipelined signed multiplier among NUM_REQ requesters.
//    A round-robin arbiter issues at most one operand pair per cycle. A small
//    {valid, id} tracker runs alongside the multiplier pipe. The tracker tags
//    each product with the requester that issued it. Products come back on a
//    single result port that uses valid/ready handshaking. A result that is
//    held at the output stalls the whole pipe, the multiplier included.
//
// Ports:
//    clk        clock, rising edge
//    reset      asynchronous active-low reset (0 = in reset)
//    req_valid  per-requester operand valid
//    req_ready  per-requester grant (one-hot or zero), combinational
//    req_a      packed signed A operands, requester i = slice i
//    req_b      packed signed B operands, requester i = slice i
//    res_valid  result valid
//    res_ready  result consumer ready
//    res_data   signed product (straight from the multiplier)
//    res_id     index of the requester that issued res_data
//    busy       any operation in flight or result pending
//    mul_ce     clock enable to the multiplier
//    mul_din0   operand A to the multiplier
//    mul_din1   operand B to the multiplier
//    mul_dout   product from the multiplier
// -----------------------------------------------------------------------------
module network_mul_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_WIDTH    = 2,
   parameter int A_WIDTH     = 16,
   parameter int B_WIDTH     = 12,
   parameter int P_WIDTH     = 28,
   parameter int MUL_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [P_WIDTH-1:0]           res_data,
   output logic [ID_WIDTH-1:0]          res_id,
   output logic                         busy,
   output logic                         mul_ce,
   output logic [A_WIDTH-1:0]           mul_din0,
   output logic [B_WIDTH-1:0]           mul_din1,
   input  logic [P_WIDTH-1:0]           mul_dout
);

   logic                w_advance;
   logic                w_grant_any;
   logic [ID_WIDTH-1:0] w_grant_id;
   logic [ID_WIDTH-1:0] w_idx;
   logic [A_WIDTH-1:0]  w_sel_a;
   logic [B_WIDTH-1:0]  w_sel_b;

   logic [ID_WIDTH-1:0]    r_ptr;
   logic [MUL_LATENCY-1:0] r_vld;
   logic [ID_WIDTH-1:0]    r_id [MUL_LATENCY];
   logic [A_WIDTH-1:0]     r_last_a;
   logic [B_WIDTH-1:0]     r_last_b;

   // The pipe moves unless a valid result is sitting unaccepted at the output.
   // A bubble at the output therefore never blocks issue.
   assign w_advance = ~(r_vld[MUL_LATENCY-1] & ~res_ready);

   // Round-robin search starts at the index after the last grant.
   // NOTE: every signal driven in this block gets a default first. Without
   // the defaults, any path that skips an assignment would infer a latch.
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_id  = '0;
      w_idx       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = ID_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
         if (!w_grant_any && req_valid[w_idx]) begin
            w_grant_any = 1'b1;
            w_grant_id  = w_idx;
         end
      end
      // Nothing is granted while stalled. Nothing is granted while reset is
      // asserted either, so req_ready reads zero during reset.
      if (!w_advance || !reset) w_grant_any = 1'b0;
   end

   always_comb begin
      req_ready = '0;
      if (w_grant_any) req_ready[w_grant_id] = 1'b1;
   end

   assign w_sel_a = req_a[int'(w_grant_id)*A_WIDTH +: A_WIDTH];
   assign w_sel_b = req_b[int'(w_grant_id)*B_WIDTH +: B_WIDTH];

   // The multiplier samples its inputs on the grant edge. The operands must
   // therefore reach it in the grant cycle. Between grants they hold the last
   // issued pair.
   assign mul_din0 = w_grant_any ? w_sel_a : r_last_a;
   assign mul_din1 = w_grant_any ? w_sel_b : r_last_b;
   assign mul_ce   = w_advance;

   // NOTE: operand holding registers are plain datapath and carry no reset.
   // Their content is meaningless until the first grant, and nothing
   // downstream reads them before that grant.
   always_ff @(posedge clk) begin
      if (w_grant_any) begin
         r_last_a <= w_sel_a;
         r_last_b <= w_sel_b;
      end
   end

   // NOTE: sequential state uses non-blocking assignments. Each stage then
   // reads the pre-edge value of its neighbour, and the shift behaves as a
   // real pipeline.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= ID_WIDTH'(NUM_REQ - 1);
         r_vld <= '0;
         for (int i = 0; i < MUL_LATENCY; i++) r_id[i] <= '0;
      end else if (w_advance) begin
         r_vld[0] <= w_grant_any;
         r_id[0]  <= w_grant_id;
         for (int i = 1; i < MUL_LATENCY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_id[i]  <= r_id[i-1];
         end
         if (w_grant_any) r_ptr <= w_grant_id;
      end
   end

   assign res_valid = r_vld[MUL_LATENCY-1];
   assign res_id    = r_id[MUL_LATENCY-1];
   assign res_data  = mul_dout;
   assign busy      = |r_vld;

endmodule
